regfile_nport: RTL

Parametrised successor to the core's single-write, dual-read register file: XLEN-bit × DEPTH-entry storage, NRD asynchronous read ports, one synchronous write port, entry 0 hardwired to zero. Adds a hardware clear sequencer that zeroes every entry after reset, a `ready` flag, write-error reporting and optional write-to-read bypass. It sits between decode (read addresses) and writeback (write port) in the single-cycle datapath.

---
 rtl/regfile_pkg.sv | 15 +
 rtl/regfile_rd_port.sv | 49 ++++
 rtl/regfile_nport.sv | 106 ++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the N-read-port register file.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package regfile_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } rf_state_t;

    localparam int RF_XLEN  = 32;
    localparam int RF_DEPTH = 32;
    localparam int RF_NRD   = 2;

endpackage

// File: rtl/regfile_rd_port.sv
// One read port: range check, zero-forcing (entry 0, out of range, clearing), optional bypass.
// Latency: combinational, zero cycles from address to data.
// Backpressure: none; always produces a value. Bypass selected by REGFILE_NPORT_BYPASS_EN.
module regfile_rd_port #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic [AW-1:0]   ra_i,
    input  logic [XLEN-1:0] word_i,
    input  logic            clear_i,
    input  logic            wr_acc_i,
    input  logic [AW-1:0]   wa_i,
    input  logic [XLEN-1:0] wd_i,
    output logic [XLEN-1:0] rd_o
);

    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

    logic ra_valid;
    assign ra_valid = !clear_i && (ra_i != '0) && ({1'b0, ra_i} < DEPTH_W);

`ifdef REGFILE_NPORT_BYPASS_EN
    // Forward an accepted same-cycle write to this port, else return stored word
    always_comb begin
        rd_o = '0;
        if (ra_valid) begin
            if (wr_acc_i && (wa_i == ra_i)) begin
                rd_o = wd_i;
            end else begin
                rd_o = word_i;
            end
        end
    end
`else
    // Write-port signals only feed the forwarding mux, absent in this build
    logic unused_wr;
    assign unused_wr = ^{wr_acc_i, wa_i, wd_i};

    // Stored contents only, zero-forced outside the readable range
    always_comb begin
        rd_o = '0;
        if (ra_valid) begin
            rd_o = word_i;
        end
    end
`endif

endmodule

// File: rtl/regfile_nport.sv
// Register file: DEPTH x XLEN, NRD async read ports, one sync write port, entry 0 = 0, post-reset clear.
// Latency: reads combinational; writes visible next cycle (same cycle with REGFILE_NPORT_BYPASS_EN).
// Backpressure: writes during clear or out of range are dropped and flagged by a one-cycle wr_err.
module regfile_nport
    import regfile_pkg::*;
#(
    parameter int XLEN  = RF_XLEN,
    parameter int DEPTH = RF_DEPTH,
    parameter int NRD   = RF_NRD,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we,
    input  logic [AW-1:0]       wa,
    input  logic [XLEN-1:0]     wd,
    input  logic [NRD*AW-1:0]   ra,
    output logic [NRD*XLEN-1:0] rd,
    output logic                ready,
    output logic                wr_err
);

    localparam logic [AW:0]   DEPTH_W  = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

    rf_state_t       state_q;
    logic [AW-1:0]   ptr_q;
    logic            ready_q;
    logic            wr_err_q;
    logic [XLEN-1:0] mem_q [DEPTH];

    logic wa_in_range;
    logic wr_acc;
    logic wr_rej;
    logic clearing;

    assign clearing    = (state_q == ST_CLEAR);
    assign wa_in_range = ({1'b0, wa} < DEPTH_W);
    // Writes to entry 0 in RUN are neither accepted nor flagged
    assign wr_acc      = we && !clearing && (wa != '0) && wa_in_range;
    assign wr_rej      = we && (clearing || !wa_in_range);

    // Clear sequencer with registered ready and write-error pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_CLEAR;
            ptr_q    <= '0;
            ready_q  <= 1'b0;
            wr_err_q <= 1'b0;
        end else begin
            wr_err_q <= wr_rej;
            case (state_q)
                ST_CLEAR: begin
                    if (ptr_q == PTR_LAST) begin
                        state_q <= ST_RUN;
                        ready_q <= 1'b1;
                        ptr_q   <= '0;
                    end else begin
                        ptr_q <= ptr_q + 1'b1;
                    end
                end
                ST_RUN: begin
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= ST_CLEAR;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    // Storage: zeroed one entry per cycle while clearing, then normal writes
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (clearing) begin
                mem_q[ptr_q] <= '0;
            end else if (wr_acc) begin
                mem_q[wa] <= wd;
            end
        end
    end

    assign ready  = ready_q;
    assign wr_err = wr_err_q;

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0] ra_k;
        assign ra_k = ra[k*AW +: AW];

        regfile_rd_port #(
            .XLEN  (XLEN),
            .DEPTH (DEPTH),
            .AW    (AW)
        ) u_rd_port (
            .ra_i     (ra_k),
            .word_i   (mem_q[ra_k]),
            .clear_i  (clearing),
            .wr_acc_i (wr_acc),
            .wa_i     (wa),
            .wd_i     (wd),
            .rd_o     (rd[k*XLEN +: XLEN])
        );
    end

endmodule
